// File: rtl/code_lock_fsm.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : code_lock_fsm
// Description : Parametrised digit-code lock. Compares a sequence of entered
//               digits against a fixed code, signals open / fail, counts
//               consecutive failures and locks out entry after MAX_TRIES.
//               All outputs are registered; a 7-segment glyph shows status.
// Revision    : 1.0 - initial release
// ============================================================================
module code_lock_fsm #(
  parameter int                            DIGIT_W     = 4,
  parameter int                            CODE_LEN    = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE        = 24'h590981,
  parameter int                            OPEN_CYCLES = 8,
  parameter int                            FAIL_CYCLES = 4,
  parameter int                            MAX_TRIES   = 3,
  parameter int                            LOCK_CYCLES = 32,
  localparam int                           TRIES_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               insere_i,
  input  logic [DIGIT_W-1:0] numero_i,
  input  logic               cancel_i,
  output logic               led_open_o,
  output logic               fail_o,
  output logic               locked_o,
  output logic [TRIES_W-1:0] tries_o,
  output logic [6:0]         seg_o
);

  // Timer must hold the longest load value (cycles - 1).
  localparam int MAX_CYC_OF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
  localparam int MAX_CYC    = (MAX_CYC_OF > LOCK_CYCLES) ? MAX_CYC_OF : LOCK_CYCLES;
  localparam int TIMER_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W      = 4;

  localparam logic [TIMER_W-1:0] C_OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_FAIL_LOAD = TIMER_W'(FAIL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [TRIES_W-1:0] C_MAX_TRIES = TRIES_W'(MAX_TRIES);
  localparam logic [IDX_W-1:0]   C_LAST_IDX  = IDX_W'(CODE_LEN - 1);

  localparam logic [1:0] S_ENTRY = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_FAIL  = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam logic [6:0] SEG_OPEN = 7'b1110111;  // "A"
  localparam logic [6:0] SEG_FAIL = 7'b1001111;  // "E"
  localparam logic [6:0] SEG_LOCK = 7'b0001110;  // "L"

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               insere_q;
  logic               led_open_q, fail_q, locked_q;
  logic [6:0]         seg_q, seg_d;

  logic               acc;
  logic               mismatch;

  // Expected digit per position, MS digit first; unused slots padded with zero.
  logic [DIGIT_W-1:0] code_digit [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_code_digit
    if (gi < CODE_LEN) begin : g_used
      assign code_digit[gi] = CODE[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
    end else begin : g_pad
      assign code_digit[gi] = '0;
    end
  end

  // A digit is accepted only on a fresh insere edge while in ENTRY.
  assign acc      = insere_i & ~insere_q & (state_q == S_ENTRY);
  assign mismatch = (numero_i != code_digit[idx_q]);

  // Hex glyph for the entry progress display.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

  // Next-state logic: digit accumulation, timers and try counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    timer_d = timer_q;
    tries_d = tries_q;
    case (state_q)
      S_ENTRY: begin
        if (cancel_i) begin
          // Cancel takes priority over a same-cycle digit, which is dropped.
          idx_d = '0;
          err_d = 1'b0;
        end else if (acc) begin
          if (idx_q == C_LAST_IDX) begin
            idx_d = '0;
            err_d = 1'b0;
            if (err_q | mismatch) begin
              state_d = S_FAIL;
              timer_d = C_FAIL_LOAD;
              tries_d = (tries_q == C_MAX_TRIES) ? tries_q : tries_q + TRIES_W'(1);
            end else begin
              state_d = S_OPEN;
              timer_d = C_OPEN_LOAD;
              tries_d = '0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            err_d = err_q | mismatch;
          end
        end
      end
      S_OPEN: begin
        tries_d = '0;
        if (timer_q == '0) state_d = S_ENTRY;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      S_FAIL: begin
        if (timer_q == '0) begin
          if (tries_q == C_MAX_TRIES) begin
            state_d = S_LOCK;
            timer_d = C_LOCK_LOAD;
          end else begin
            state_d = S_ENTRY;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        if (timer_q == '0) begin
          tries_d = '0;
          state_d = S_ENTRY;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
    endcase
  end

  // Display glyph follows the next state so it is registered alongside it.
  always_comb begin
    seg_d = hex_glyph(idx_d);
    case (state_d)
      S_OPEN:  seg_d = SEG_OPEN;
      S_FAIL:  seg_d = SEG_FAIL;
      S_LOCK:  seg_d = SEG_LOCK;
      default: seg_d = hex_glyph(idx_d);
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ENTRY;
      idx_q      <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      tries_q    <= '0;
      insere_q   <= 1'b0;
      led_open_q <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      seg_q      <= 7'b1111110;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      tries_q    <= tries_d;
      insere_q   <= insere_i;
      led_open_q <= (state_d == S_OPEN);
      fail_q     <= (state_d == S_FAIL);
      locked_q   <= (state_d == S_LOCK);
      seg_q      <= seg_d;
    end
  end

  assign led_open_o = led_open_q;
  assign fail_o     = fail_q;
  assign locked_o   = locked_q;
  assign tries_o    = tries_q;
  assign seg_o      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_code_lock_fsm
// Description : Self-checking bench for code_lock_fsm. Vector records carry
//               stimulus and the expected registered outputs one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_lock_fsm;

  typedef struct packed {
    logic        rst;
    logic        ins;
    logic [3:0]  num;
    logic        can;
    logic [11:0] exp;   // {led_open, fail, locked, tries[1:0], seg[6:0]}
  } vec_t;

  localparam logic [6:0] GLY [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47 };
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_L = 7'b0001110;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere_i;
  logic [3:0] numero_i;
  logic       cancel_i;
  logic       led_open_o, fail_o, locked_o;
  logic [1:0] tries_o;
  logic [6:0] seg_o;

  vec_t        vecs [$];
  logic [11:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  code_lock_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .insere_i   (insere_i),
    .numero_i   (numero_i),
    .cancel_i   (cancel_i),
    .led_open_o (led_open_o),
    .fail_o     (fail_o),
    .locked_o   (locked_o),
    .tries_o    (tries_o),
    .seg_o      (seg_o)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic led, input logic fl, input logic lk,
                                     input int tr, input logic [6:0] sg);
    return {led, fl, lk, 2'(tr), sg};
  endfunction

  function automatic void add(input logic r, input logic i, input logic [3:0] n,
                              input logic c, input logic [11:0] e);
    vec_t v;
    v.rst = r; v.ins = i; v.num = n; v.can = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  // One insere pulse (high then low); both cycles expect the same outputs.
  function automatic void add_digit(input logic [3:0] n, input logic [11:0] e);
    add(1'b0, 1'b1, n, 1'b0, e);
    add(1'b0, 1'b0, 4'd0, 1'b0, e);
  endfunction

  // Correct code 590981 ending in the 8-cycle open window and return to "0".
  function automatic void add_open_code(input int tries_before);
    logic [3:0] d [5] = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8};
    for (int k = 0; k < 5; k++) add_digit(d[k], ex(0, 0, 0, tries_before, GLY[k+1]));
    add(1'b0, 1'b1, 4'd1, 1'b0, ex(1, 0, 0, 0, SEG_A));
    for (int k = 0; k < 7; k++) add(1'b0, 1'b0, 4'd0, 1'b0, ex(1, 0, 0, 0, SEG_A));
    add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 0, GLY[0]));
  endfunction

  // Drive one vector before the edge, check the outputs just after it.
  task automatic cyc(input vec_t v, input string name);
    logic [11:0] act, expv;
    @(negedge clk);
    reset    = v.rst;
    insere_i = v.ins;
    numero_i = v.num;
    cancel_i = v.can;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    act  = {led_open_o, fail_o, locked_o, tries_o, seg_o};
    expv = sb_q.pop_front();
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got {led,fail,lock,tries,seg}=%b required %b", name, act, expv);
    end
  endtask

  task automatic apply_table(input string tag);
    for (int k = 0; k < vecs.size(); k++) cyc(vecs[k], $sformatf("%s_row%0d", tag, k));
    vecs.delete();
  endtask

  task automatic row(input logic r, input logic i, input logic [3:0] n,
                     input logic c, input logic [11:0] e, input string name);
    vec_t v;
    v.rst = r; v.ins = i; v.num = n; v.can = c; v.exp = e;
    cyc(v, name);
  endtask

  // A wrong code (all digits 0xA) from tries_before, through its 4 fail cycles.
  task automatic wrong_code(input int tb_tries, input string name);
    for (int k = 0; k < 5; k++) begin
      row(0, 1, 4'hA, 0, ex(0, 0, 0, tb_tries, GLY[k+1]), name);
      row(0, 0, 4'h0, 0, ex(0, 0, 0, tb_tries, GLY[k+1]), name);
    end
    row(0, 1, 4'hA, 0, ex(0, 1, 0, tb_tries + 1, SEG_E), name);
    for (int k = 0; k < 3; k++) row(0, 0, 4'h0, 0, ex(0, 1, 0, tb_tries + 1, SEG_E), name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; insere_i = 1'b0; numero_i = 4'd0; cancel_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state and T1: correct code opens for 8 cycles.
    add(1'b1, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 0, GLY[0]));
    add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 0, GLY[0]));
    add_open_code(0);
    // T2: mismatch in the 3rd digit, no early abort, fail for 4 cycles.
    begin
      logic [3:0] d [5] = '{4'd5, 4'd9, 4'd7, 4'd9, 4'd8};
      for (int k = 0; k < 5; k++) add_digit(d[k], ex(0, 0, 0, 0, GLY[k+1]));
    end
    add(1'b0, 1'b1, 4'd1, 1'b0, ex(0, 1, 0, 1, SEG_E));
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 1, 0, 1, SEG_E));
    add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 1, GLY[0]));
    // T4: insere held high five cycles counts once.
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 4'd5, 1'b0, ex(0, 0, 0, 1, GLY[1]));
    add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 1, GLY[1]));
    add(1'b0, 1'b0, 4'd0, 1'b1, ex(0, 0, 0, 1, GLY[0]));
    // T5: cancel with a same-cycle edge after 3 digits drops the digit.
    add_digit(4'd5, ex(0, 0, 0, 1, GLY[1]));
    add_digit(4'd9, ex(0, 0, 0, 1, GLY[2]));
    add_digit(4'd0, ex(0, 0, 0, 1, GLY[3]));
    add(1'b0, 1'b1, 4'd9, 1'b1, ex(0, 0, 0, 1, GLY[0]));
    add(1'b0, 1'b0, 4'd0, 1'b0, ex(0, 0, 0, 1, GLY[0]));
    add_open_code(1);
    apply_table("tbl");

    // T3: three wrong codes, 32-cycle lockout ignoring insere, then open.
    wrong_code(0, "t3_try1");
    row(0, 0, 0, 0, ex(0, 0, 0, 1, GLY[0]), "t3_back1");
    wrong_code(1, "t3_try2");
    row(0, 0, 0, 0, ex(0, 0, 0, 2, GLY[0]), "t3_back2");
    wrong_code(2, "t3_try3");
    for (int j = 0; j < 32; j++)
      row(0, (j % 2 == 0) && (j < 31), 4'd5, 0, ex(0, 0, 1, 3, SEG_L), "t3_lock");
    row(0, 0, 0, 0, ex(0, 0, 0, 0, GLY[0]), "t3_unlock");
    add_open_code(0);
    apply_table("t3_open");

    // T6a: reset after 4 digits with tries nonzero; insere high through reset
    // still gives an entry on the following cycle.
    wrong_code(0, "t6_wrong");
    row(0, 0, 0, 0, ex(0, 0, 0, 1, GLY[0]), "t6_back");
    for (int k = 0; k < 4; k++) begin
      row(0, 1, 4'd5, 0, ex(0, 0, 0, 1, GLY[k+1]), "t6_dig");
      row(0, 0, 4'd0, 0, ex(0, 0, 0, 1, GLY[k+1]), "t6_dig");
    end
    row(1, 1, 4'd5, 0, ex(0, 0, 0, 0, GLY[0]), "t6_reset_mid");
    row(0, 1, 4'd5, 0, ex(0, 0, 0, 0, GLY[1]), "t6_post_reset_edge");
    row(0, 0, 4'd0, 1, ex(0, 0, 0, 0, GLY[0]), "t6_cancel");

    // T6b: reset during lockout.
    wrong_code(0, "t6_l1");
    row(0, 0, 0, 0, ex(0, 0, 0, 1, GLY[0]), "t6_l1b");
    wrong_code(1, "t6_l2");
    row(0, 0, 0, 0, ex(0, 0, 0, 2, GLY[0]), "t6_l2b");
    wrong_code(2, "t6_l3");
    for (int j = 0; j < 5; j++) row(0, 0, 0, 0, ex(0, 0, 1, 3, SEG_L), "t6_locked");
    row(1, 0, 0, 0, ex(0, 0, 0, 0, GLY[0]), "t6_reset_lock");
    row(0, 1, 4'd5, 0, ex(0, 0, 0, 0, GLY[1]), "t6_after_lock");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
